cpu_axi_read_arbiter: RTL
=========================

# cpu_axi_read_arbiter

Shares one AXI4 read channel pair (AR/R) between the CPU instruction-fetch port and the data-load port. Each requester has a one-entry slot tracking its single outstanding read; slots contend for AR through a round-robin arbiter, and R beats are steered back by ARID. It sits between the pipeline's SRAM-like fetch/load ports and the AXI crossbar, beside the existing write path.

## Interface
Parameters:
- INSTRUCTION_ID, 4'd0, ARID used for instruction reads
- DATA_ID, 4'd1, ARID used for data reads; must differ from INSTRUCTION_ID

Ports:
- clock  in  1  sole clock, rising edge
- reset_  in  1  asynchronous, active-low reset
- instruction_ram_request / data_ram_request  in  1  read request
- instruction_ram_size / data_ram_size  in  2  log2 bytes
- instruction_ram_address / data_ram_address  in  32  byte address
- instruction_ram_address_ready / data_ram_address_ready  out  1  request accepted this cycle
- instruction_ram_data_ready / data_ram_data_ready  out  1  one-cycle pulse, read data valid
- instruction_ram_read_data / data_ram_read_data  out  32  returned data, held until next return
- axi_read_address_id  out  4; axi_read_address  out  32; axi_read_address_size  out  3
- axi_read_address_length  out  8 (8'd0); axi_read_address_burst  out  2 (2'b01); axi_read_address_lock  out  2 (0); axi_read_address_cache  out  4 (0); axi_read_address_protection  out  3 (0)
- axi_read_address_valid  out  1; axi_read_address_ready  in  1
- axi_read_data_id  in  4; axi_read_data  in  32; axi_read_data_response  in  2; axi_read_data_last  in  1
- axi_read_data_valid  in  1; axi_read_data_ready  out  1

## Operation
- Per slot (instruction, data) states: IDLE, PENDING, ISSUED, RETURN.
- IDLE: *_address_ready = request (combinational); on request capture address and size, go PENDING.
- PENDING: eligible for AR grant. Granted slot drives AR from its capture registers; ARID = slot ID; ARSIZE = {1'b0,size}. On valid&ready go ISSUED.
- ISSUED: accepts R beat when axi_read_data_valid and axi_read_data_id equals slot ID; capture axi_read_data, go RETURN. Response code and last are ignored (single-beat only).
- RETURN: *_data_ready = 1 for exactly this cycle; next state IDLE.
- axi_read_data_ready = (id==INSTRUCTION_ID & inst slot ISSUED) | (id==DATA_ID & data slot ISSUED). Beats with any other ID stall (ready low).
- Arbiter: grant register plus last_grant bit. When no grant is held, pick among PENDING slots; if both, pick the one not equal to last_grant; update last_grant on pick. Grant held while axi_read_address_valid until AR handshake; AR payload and valid never change while valid=1 and ready=0.
- Both slots may be ISSUED simultaneously; R beats may return in any order.

## Timing
- Reset (reset_ low, asynchronous): all slots IDLE, no grant, last_grant = data (so instruction wins first tie), all outputs 0 except constant AR fields; read_data registers 0.
- Request to AR valid: 2 cycles minimum (accept cycle, grant cycle; AR valid registered).
- AR handshake to earliest R acceptance: 1 cycle. R acceptance to data_ready: 1 cycle. Best-case request-to-data_ready: 4 cycles with zero-latency slave.
- Requester may issue the next request in the cycle after data_ready (slot IDLE).
- Simultaneous R beat for one slot and AR handshake for the other in the same cycle: both processed.
- Reset mid-transaction discards slots; in-flight R beats after reset are not accepted (ready 0 since no slot ISSUED).

## Configuration
- CPU_AXI_READ_ARBITER_DATA_PRIORITY_EN defined: fixed priority, data slot always wins a tie; last_grant unused.
- Undefined: round-robin as above.

## Test plan
- Single fetch: instruction request addr 0xBFC00000 size 2, zero-wait slave returns 0x3C1D0001 -> AR id 0 addr 0xBFC00000 size 3'd2 in cycle 2, instruction_ram_data_ready pulse cycle 4 with data 0x3C1D0001.
- Tie after reset: both request same cycle (0x1000, 0x2000) -> AR order id 0 then id 1; repeat tie -> data first (round-robin); with macro defined -> data first both times.
- Out-of-order return: both ISSUED, slave returns id 1 (0xAAAA5555) before id 0 (0x12345678) -> data_ready first with 0xAAAA5555, then instruction_ram_data_ready with 0x12345678.
- AR backpressure: axi_read_address_ready low 5 cycles -> valid, addr, id stable all 5 cycles; other slot's request accepted into PENDING but not driven.
- Unknown ID: R valid with id 4'd7 -> axi_read_data_ready 0, no data_ready pulse.
- Async reset asserted while both slots ISSUED -> outputs 0 immediately; subsequent fetch of 0x4 completes normally.

Source files
------------

// File: rtl/cpu_axi_read_arbiter.sv
// ============================================================================
// Module   : cpu_axi_read_arbiter
// Brief    : Shares one AXI4 AR/R channel pair between the instruction-fetch
//            and data-load ports; one outstanding read per port, R steered
//            by ARID. Define CPU_AXI_READ_ARBITER_DATA_PRIORITY_EN for fixed
//            data-first arbitration instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_axi_read_arbiter #(
    parameter logic [3:0] INSTRUCTION_ID = 4'd0,
    parameter logic [3:0] DATA_ID        = 4'd1
) (
    input  logic        clock,
    input  logic        reset_,
    input  logic        instruction_ram_request,
    input  logic [1:0]  instruction_ram_size,
    input  logic [31:0] instruction_ram_address,
    output logic        instruction_ram_address_ready,
    output logic        instruction_ram_data_ready,
    output logic [31:0] instruction_ram_read_data,
    input  logic        data_ram_request,
    input  logic [1:0]  data_ram_size,
    input  logic [31:0] data_ram_address,
    output logic        data_ram_address_ready,
    output logic        data_ram_data_ready,
    output logic [31:0] data_ram_read_data,
    output logic [3:0]  axi_read_address_id,
    output logic [31:0] axi_read_address,
    output logic [2:0]  axi_read_address_size,
    output logic [7:0]  axi_read_address_length,
    output logic [1:0]  axi_read_address_burst,
    output logic [1:0]  axi_read_address_lock,
    output logic [3:0]  axi_read_address_cache,
    output logic [2:0]  axi_read_address_protection,
    output logic        axi_read_address_valid,
    input  logic        axi_read_address_ready,
    input  logic [3:0]  axi_read_data_id,
    input  logic [31:0] axi_read_data,
    input  logic [1:0]  axi_read_data_response,
    input  logic        axi_read_data_last,
    input  logic        axi_read_data_valid,
    output logic        axi_read_data_ready
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_ISSUED  = 2'd2;
    localparam logic [1:0] S_RETURN  = 2'd3;
    localparam logic       SEL_INST  = 1'b0;
    localparam logic       SEL_DATA  = 1'b1;

    logic [1:0]  r_inst_state, r_data_state;
    logic [31:0] r_inst_addr, r_data_addr;
    logic [1:0]  r_inst_size, r_data_size;
    logic [31:0] r_inst_rdata, r_data_rdata;
    logic        r_ar_valid;
    logic        r_grant;

    logic w_inst_pending, w_data_pending;
    logic w_inst_r_match, w_data_r_match;
    logic w_ar_fire;
    logic w_pick_valid, w_pick_sel;

    // Single-beat reads only: response code and last flag carry no information here.
    logic unused_r_fields;
    assign unused_r_fields = ^{axi_read_data_response, axi_read_data_last};

    assign w_inst_pending = (r_inst_state == S_PENDING);
    assign w_data_pending = (r_data_state == S_PENDING);
    assign w_inst_r_match = (axi_read_data_id == INSTRUCTION_ID) && (r_inst_state == S_ISSUED);
    assign w_data_r_match = (axi_read_data_id == DATA_ID) && (r_data_state == S_ISSUED);
    assign w_ar_fire      = r_ar_valid && axi_read_address_ready;
    assign w_pick_valid   = !r_ar_valid && (w_inst_pending || w_data_pending);

`ifdef CPU_AXI_READ_ARBITER_DATA_PRIORITY_EN
    assign w_pick_sel = w_data_pending ? SEL_DATA : SEL_INST;
`else
    logic r_last_grant;
    assign w_pick_sel = (w_inst_pending && w_data_pending) ? ~r_last_grant
                                                           : (w_data_pending ? SEL_DATA : SEL_INST);
`endif

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_ar_valid <= 1'b0;
            r_grant    <= SEL_INST;
`ifndef CPU_AXI_READ_ARBITER_DATA_PRIORITY_EN
            r_last_grant <= SEL_DATA;
`endif
        end else if (w_ar_fire) begin
            r_ar_valid <= 1'b0;
        end else if (w_pick_valid) begin
            r_ar_valid <= 1'b1;
            r_grant    <= w_pick_sel;
`ifndef CPU_AXI_READ_ARBITER_DATA_PRIORITY_EN
            // Only contended picks move the pointer, so an uncontested grant cannot starve the loser.
            if (w_inst_pending && w_data_pending)
                r_last_grant <= w_pick_sel;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_inst_state <= S_IDLE;
            r_inst_addr  <= 32'd0;
            r_inst_size  <= 2'd0;
            r_inst_rdata <= 32'd0;
        end else begin
            case (r_inst_state)
                S_IDLE: if (instruction_ram_request) begin
                    r_inst_addr  <= instruction_ram_address;
                    r_inst_size  <= instruction_ram_size;
                    r_inst_state <= S_PENDING;
                end
                S_PENDING: if (w_ar_fire && (r_grant == SEL_INST)) r_inst_state <= S_ISSUED;
                S_ISSUED: if (axi_read_data_valid && w_inst_r_match) begin
                    r_inst_rdata <= axi_read_data;
                    r_inst_state <= S_RETURN;
                end
                default: r_inst_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_data_state <= S_IDLE;
            r_data_addr  <= 32'd0;
            r_data_size  <= 2'd0;
            r_data_rdata <= 32'd0;
        end else begin
            case (r_data_state)
                S_IDLE: if (data_ram_request) begin
                    r_data_addr  <= data_ram_address;
                    r_data_size  <= data_ram_size;
                    r_data_state <= S_PENDING;
                end
                S_PENDING: if (w_ar_fire && (r_grant == SEL_DATA)) r_data_state <= S_ISSUED;
                S_ISSUED: if (axi_read_data_valid && w_data_r_match) begin
                    r_data_rdata <= axi_read_data;
                    r_data_state <= S_RETURN;
                end
                default: r_data_state <= S_IDLE;
            endcase
        end
    end

    assign instruction_ram_address_ready = (r_inst_state == S_IDLE) && instruction_ram_request;
    assign data_ram_address_ready        = (r_data_state == S_IDLE) && data_ram_request;
    assign instruction_ram_data_ready    = (r_inst_state == S_RETURN);
    assign data_ram_data_ready           = (r_data_state == S_RETURN);
    assign instruction_ram_read_data     = r_inst_rdata;
    assign data_ram_read_data            = r_data_rdata;

    assign axi_read_address_valid = r_ar_valid;
    assign axi_read_address_id    = !r_ar_valid ? 4'd0 :
                                    ((r_grant == SEL_DATA) ? DATA_ID : INSTRUCTION_ID);
    assign axi_read_address       = !r_ar_valid ? 32'd0 :
                                    ((r_grant == SEL_DATA) ? r_data_addr : r_inst_addr);
    assign axi_read_address_size  = !r_ar_valid ? 3'd0 :
                                    {1'b0, ((r_grant == SEL_DATA) ? r_data_size : r_inst_size)};

    assign axi_read_address_length     = 8'd0;
    assign axi_read_address_burst      = 2'b01;
    assign axi_read_address_lock       = 2'd0;
    assign axi_read_address_cache      = 4'd0;
    assign axi_read_address_protection = 3'd0;

    assign axi_read_data_ready = w_inst_r_match || w_data_r_match;

endmodule

`default_nettype wire
